// File: rtl/fir_seq_ctrl.sv
// fir_seq_ctrl: ap_ctrl_hs sequencer feeding one fir call per streamed sample, with watchdog and sticky errors
module fir_seq_ctrl #(
  parameter int XW = 8,
  parameter int YW = 16,
  parameter int TMO = 255,
  parameter int CNT_W = 16
) (
  input  logic             ap_clk,
  input  logic             ap_rst,
  input  logic [XW-1:0]    in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [YW-1:0]    out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             fir_start,
  output logic [XW-1:0]    fir_x,
  input  logic             fir_done,
  input  logic             fir_idle,
  input  logic             fir_ready,
  input  logic [YW-1:0]    fir_y,
  input  logic             fir_y_vld,
  input  logic             clr_err,
  output logic             err_tmo,
  output logic             err_noy,
  output logic [CNT_W-1:0] smp_cnt
);
  localparam int WW = $clog2(TMO + 1);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_OUT} state_t;
  state_t state, state_n;
  logic [WW-1:0] wdog, wdog_n;
  logic [XW-1:0] fir_x_n;
  logic [YW-1:0] out_data_n;
  logic [CNT_W-1:0] smp_cnt_n;
  logic ygot, ygot_n, fir_start_n, out_valid_n, set_tmo, set_noy, acc, tmo, have_y;
  assign in_ready = state == S_IDLE && fir_idle;
  assign acc = in_ready && in_valid;
  assign tmo = wdog == WW'(TMO);
  assign have_y = ygot || fir_y_vld;
  always_comb begin
    state_n = state;
    fir_start_n = fir_start;
    fir_x_n = fir_x;
    out_data_n = out_data;
    out_valid_n = out_valid;
    ygot_n = ygot;
    wdog_n = wdog;
    smp_cnt_n = smp_cnt;
    set_tmo = 1'b0;
    set_noy = 1'b0;
    case (state)
      S_IDLE: if (acc) begin
        state_n = S_RUN;
        fir_x_n = in_data;
        fir_start_n = 1'b1;
        wdog_n = '0;
        ygot_n = 1'b0;
      end
      S_RUN: begin
        wdog_n = wdog + WW'(1);
        fir_start_n = fir_start && !fir_ready;
        out_data_n = fir_y_vld ? fir_y : out_data;
        ygot_n = have_y;
        if (fir_done) begin
          fir_start_n = 1'b0;
          state_n = have_y ? S_OUT : S_IDLE;
          out_valid_n = have_y;
          set_noy = !have_y;
        end else if (tmo) begin
          fir_start_n = 1'b0;
          set_tmo = 1'b1;
          state_n = S_IDLE;
        end
      end
      S_OUT: if (out_ready) begin
        out_valid_n = 1'b0;
        smp_cnt_n = smp_cnt + CNT_W'(1);
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state <= S_IDLE;
      fir_start <= 1'b0;
      fir_x <= '0;
      out_data <= '0;
      out_valid <= 1'b0;
      ygot <= 1'b0;
      wdog <= '0;
      smp_cnt <= '0;
      err_tmo <= 1'b0;
      err_noy <= 1'b0;
    end else begin
      state <= state_n;
      fir_start <= fir_start_n;
      fir_x <= fir_x_n;
      out_data <= out_data_n;
      out_valid <= out_valid_n;
      ygot <= ygot_n;
      wdog <= wdog_n;
      smp_cnt <= smp_cnt_n;
      err_tmo <= set_tmo || (err_tmo && !clr_err);
      err_noy <= set_noy || (err_noy && !clr_err);
    end
  end
endmodule

// File: tb/tb_fir_seq_ctrl.sv
// tb_fir_seq_ctrl: scoreboard bench with a behavioural ap_ctrl_hs fir core and a golden 8-tap FIR reference
module tb_fir_seq_ctrl;
  localparam int TMO = 8;
  localparam int CW = 8;
  localparam int C [8] = '{1, 3, 5, 7, 7, 5, 3, 1};
  logic clk = 0, rst = 1;
  logic [7:0] in_data = 0;
  logic in_valid = 0, in_ready;
  logic [15:0] out_data;
  logic out_valid, out_ready = 0;
  logic fir_start;
  logic [7:0] fir_x;
  logic fir_done = 0, fir_idle = 0, fir_ready = 0, fir_y_vld = 0;
  logic [15:0] fir_y = 0;
  logic clr_err = 0, err_tmo, err_noy;
  logic [CW-1:0] smp_cnt;
  int n_chk = 0, n_fail = 0;
  int cfg_r = 0, cfg_d = 0, cfg_ym = 0;
  bit cfg_h = 0, idle_off = 1, bp = 0;
  logic [15:0] exp_q [$];
  logic [7:0] sh [8];
  fir_seq_ctrl #(.XW(8), .YW(16), .TMO(TMO), .CNT_W(CW)) dut (
    .ap_clk(clk), .ap_rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .fir_start(fir_start),
    .fir_x(fir_x), .fir_done(fir_done), .fir_idle(fir_idle), .fir_ready(fir_ready), .fir_y(fir_y),
    .fir_y_vld(fir_y_vld), .clr_err(clr_err), .err_tmo(err_tmo), .err_noy(err_noy), .smp_cnt(smp_cnt)
  );
  always #5 clk = ~clk;
  function automatic logic [15:0] golden(input logic [7:0] h [8]);
    int s;
    s = 0;
    for (int i = 0; i < 8; i++) s += C[i] * int'(h[i]);
    return 16'(s);
  endfunction
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  bit busy = 0;
  int t = 0, cr = 0, cd = 0, cym = 0;
  logic [7:0] ch [8];
  logic [15:0] cy = 0;
  always @(posedge clk) begin
    #1;
    if (rst) begin
      busy = 0;
      t = 0;
      foreach (ch[i]) ch[i] = 0;
    end else begin
      if (busy) begin
        t++;
        if (!cfg_h && t > cd) busy = 0;
      end
      if (!busy && fir_start) begin
        busy = 1;
        t = 0;
        cr = cfg_r;
        cd = cfg_d;
        cym = cfg_ym;
        for (int i = 7; i > 0; i--) ch[i] = ch[i-1];
        ch[0] = fir_x;
        cy = golden(ch);
      end
    end
    fir_ready = busy && t == cr;
    fir_done = busy && !cfg_h && t == cd;
    fir_y_vld = busy && !cfg_h && ((t == cd && (cym == 0 || cym == 2)) || (t == cd - 1 && (cym == 1 || cym == 2)));
    fir_y = (t == cd || cym == 1) ? cy : ~cy;
    fir_idle = !busy && !idle_off;
  end
  int exp_cnt = 0;
  bit pv = 0, pr = 0;
  logic [15:0] pd = 0;
  always @(negedge clk) begin
    if (rst) begin
      exp_cnt = 0;
      pv = 0;
      out_ready = 0;
    end else begin
      check("smp_cnt", 32'(smp_cnt), 32'(exp_cnt % 256));
      if (pv && !pr) check("out_hold", {out_valid, out_data}, {1'b1, pd});
      if (out_valid) check("out_quiet", {in_ready, fir_start}, 2'b00);
      out_ready = !bp && $urandom_range(3) != 0;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL out_unexpected: got %0h expected no output", out_data);
        end else check("out_data", out_data, exp_q.pop_front());
        exp_cnt++;
      end
      pv = out_valid;
      pr = out_ready;
      pd = out_data;
    end
  end
  task automatic send(input logic [7:0] x, input int r, input int d, input int ym, input bit h);
    int n;
    n = 0;
    in_data = x;
    in_valid = 1;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("accept", in_ready, 1);
    if (in_ready) begin
      cfg_r = r;
      cfg_d = d;
      cfg_ym = ym;
      cfg_h = h;
      for (int i = 7; i > 0; i--) sh[i] = sh[i-1];
      sh[0] = x;
      if (ym != 3 && !h) exp_q.push_back(golden(sh));
    end
    @(negedge clk);
    in_valid = 0;
  endtask
  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("drain", exp_q.size(), 0);
  endtask
  int n, sd, sr, sym;
  logic [15:0] d0;
  initial begin
    foreach (sh[i]) sh[i] = 0;
    repeat (2) @(negedge clk);
    check("rst_outs", {fir_start, fir_x, out_valid, out_data, err_tmo, err_noy, smp_cnt, in_ready}, 0);
    rst = 0;
    @(negedge clk);
    check("idle_gate", in_ready, 0);
    idle_off = 0;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    send(8'h05, 1, 4, 0, 0);
    check("single_c0", {fir_start, fir_x}, {1'b1, 8'h05});
    @(negedge clk);
    check("single_c1", fir_start, 1);
    @(negedge clk);
    check("single_c2", fir_start, 0);
    drain();
    check("single_cnt", smp_cnt, 1);
    bp = 1;
    send(8'($urandom), 0, 2, 0, 0);
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("bp_valid", out_valid, 1);
    d0 = out_data;
    in_data = 8'($urandom);
    in_valid = 1;
    repeat (10) begin
      @(negedge clk);
      check("bp_hold", {out_valid, out_data, in_ready, fir_start}, {1'b1, d0, 2'b00});
    end
    in_valid = 0;
    bp = 0;
    drain();
    send(8'($urandom), 1, 3, 3, 0);
    n = 0;
    while (!err_noy && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("noy_set", {err_noy, out_valid, smp_cnt}, {2'b10, 8'd2});
    clr_err = 1;
    @(negedge clk);
    clr_err = 0;
    check("noy_clr", err_noy, 0);
    clr_err = 1;
    send(8'($urandom), 0, 2, 3, 0);
    n = 0;
    while (!err_noy && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("set_wins", err_noy, 1);
    @(negedge clk);
    check("clr_held", err_noy, 0);
    clr_err = 0;
    send(8'($urandom), 99, 4, 0, 1);
    repeat (TMO) @(negedge clk);
    check("tmo_pre", {err_tmo, fir_start}, 2'b01);
    @(negedge clk);
    check("tmo_set", {err_tmo, fir_start, in_ready, out_valid}, 4'b1000);
    cfg_h = 0;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("tmo_idle", {in_ready, err_tmo}, 2'b11);
    clr_err = 1;
    @(negedge clk);
    clr_err = 0;
    check("tmo_clr", err_tmo, 0);
    rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
    foreach (sh[i]) sh[i] = 0;
    exp_q.delete();
    check("rst2_cnt", smp_cnt, 0);
    for (int k = 0; k < 300; k++) begin
      sd = $urandom_range(6);
      sr = $urandom_range(sd);
      sym = sd == 0 ? 0 : $urandom_range(2);
      send(8'($urandom), sr, sd, sym, 0);
    end
    drain();
    check("stream_cnt", smp_cnt, 44);
    check("stream_err", {err_tmo, err_noy}, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
